// File: rtl/seq_mult4_ctrl_pkg.sv
// Shared constants, state encoding and shift helper for the sequential 4x4 multiplier.
package seq_mult4_ctrl_pkg;

    localparam int unsigned OpWidth   = 4;
    localparam int unsigned ProdWidth = 8;
    localparam int unsigned Steps     = 4;
    localparam int unsigned StepWidth = 2;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    // Step k pairs digit k[1] of a with digit k[0] of b; weight is 2*(i+j) bits.
    function automatic logic [2:0] shift_amt(input logic [StepWidth-1:0] step);
        logic [1:0] dsum;
        dsum = {1'b0, step[1]} + {1'b0, step[0]};
        return {dsum, 1'b0};
    endfunction

endpackage

// File: rtl/seq_mult4_ctrl_if.sv
// Operand/product handshake bundle for seq_mult4_ctrl.
interface seq_mult4_ctrl_if;
    import seq_mult4_ctrl_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OpWidth-1:0]   a;
    logic [OpWidth-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [ProdWidth-1:0] product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/twobit_multiplier.sv
// Shared 2x2 unsigned combinational multiplier used once per step.
module twobit_multiplier (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] m
);

    assign m = {2'b00, x} * {2'b00, y};

endmodule

// File: rtl/seq_mult4_ctrl.sv
// Sequential 4x4 multiplier: one 2x2 multiplier time-shared over four accumulate steps.
module seq_mult4_ctrl
    import seq_mult4_ctrl_pkg::*;
(
    input logic             clk,
    input logic             rst,
    seq_mult4_ctrl_if.slave bus_io
);

    state_e               state_q;
    logic [OpWidth-1:0]   a_q;
    logic [OpWidth-1:0]   b_q;
    logic [ProdWidth-1:0] acc_q;
    logic [ProdWidth-1:0] acc_d;
    logic [StepWidth-1:0] step_q;
    logic                 out_valid_q;

    logic [1:0]           a_dig;
    logic [1:0]           b_dig;
    logic [3:0]           part;

    always_comb begin
        a_dig = a_q[{step_q[1], 1'b0} +: 2];
        b_dig = b_q[{step_q[0], 1'b0} +: 2];
        // Max product 225 fits in 8 bits, so the sum never wraps.
        acc_d = acc_q + (ProdWidth'(part) << shift_amt(step_q));
    end

    twobit_multiplier u_mult (
        .x (a_dig),
        .y (b_dig),
        .m (part)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        a_q     <= bus_io.a;
                        b_q     <= bus_io.b;
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == StepWidth'(Steps - 1)) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.product   = acc_q;

endmodule

// File: doc/seq_mult4_ctrl.md
SEQ_MULT4_CTRL -- requirements
Module: seq_mult4_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, product width at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 a  input  4  multiplicand, unsigned.
REQ-007 b  input  4  multiplier, unsigned.
REQ-008 out_valid  output  1  product is valid and held.
REQ-009 out_ready  input  1  consumer takes the product this cycle.
REQ-010 product  output  8  unsigned a*b.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL compute a*b by time-sharing one 2x2 combinational multiplier over four steps, without any wider multiplier.
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and busy SHALL equal (state != IDLE).
REQ-015 Acceptance occurs on an edge with in_valid=1 and in_ready=1; a and b SHALL be latched, the accumulator cleared to 0, the step counter set to 0, and the state moved to CALC.
REQ-016 in_valid SHALL be ignored in CALC and DONE; a and b SHALL NOT affect a calculation in progress.
REQ-017 In CALC, step k (0..3) SHALL select digit i=k[1] of latched a and digit j=k[0] of latched b, and add (a_digit_i * b_digit_j) << 2*(i+j) into the 8-bit accumulator.
REQ-018 After step 3 the state SHALL go to DONE; out_valid SHALL rise exactly 4 clock edges after the acceptance edge.
REQ-019 The accumulator SHALL never overflow, since the maximum product is 225; the final value SHALL equal a*b exactly.
REQ-020 In DONE, out_valid SHALL be 1, and product SHALL hold constant until the handshake.
REQ-021 On an edge in DONE with out_ready=1, the state SHALL return to IDLE and out_valid SHALL be 0 from the next cycle.
REQ-022 If out_ready stays 0, the block SHALL remain in DONE indefinitely with product stable.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 In IDLE, product SHALL keep the last completed result until the next acceptance.
REQ-025 The minimum issue interval SHALL be 6 cycles: accept, 4 CALC steps, DONE with out_ready=1 in the same cycle, then back to IDLE.

Reset
REQ-026 When rst=1 at an edge, the state SHALL become IDLE, with accumulator/product=0, step counter=0, out_valid=0, busy=0, and in_ready=1 the next cycle.
REQ-027 rst SHALL take priority over acceptance and over the out_ready handshake.
REQ-028 A reset during CALC or DONE SHALL discard the operation, and no out_valid pulse SHALL follow.

Structure
REQ-029 Shared package/include SHALL hold the state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b10), STEPS=4, and the operand/product width constants.
REQ-030 The block SHALL instantiate exactly one sub-module, twobit_multiplier (ports x[1:0], y[1:0], m[3:0]), as the shared 2x2 datapath.
REQ-031 The shifting and accumulation SHALL be implemented in seq_mult4_ctrl.

Verification
REQ-032 Max operands: accept a=15, b=15 -> out_valid 4 edges later, product=225; out_ready=1 returns the FSM to IDLE the next cycle.
REQ-033 Zero and mixed operands: a=0, b=13 -> product=0; a=9, b=6 -> product=54; a=2, b=3 -> product=6.
REQ-034 Backpressure: a=7, b=11 with out_ready held low for 3 cycles in DONE -> product=77 stable and out_valid=1 throughout; released on the out_ready edge.
REQ-035 Busy ignore: after accepting a=3, b=5, drive in_valid=1 with a=15, b=15 during CALC -> product=15, in_ready=0 throughout CALC/DONE.
REQ-036 Reset mid-operation: rst=1 on step 2 of a=12, b=12 -> next cycle IDLE, product=0, no out_valid; a new a=4, b=4 then yields 16.
REQ-037 Back-to-back: in_valid held high across two transactions (5*5, then 14*3) -> results 25 then 42, second acceptance only once in IDLE.
